// File: rtl/rs232_pkg.sv
// Shared constants and types for the RS-232 transmit-path arbiter.
package rs232_pkg;

    // Header byte base; the low bits carry the channel number.
    localparam logic [7:0] RS232_HDR_BASE = 8'hA0;

    // Largest channel count the header encoding supports.
    localparam int unsigned MAX_CHAN = 8;

    typedef enum logic [0:0] {
        IDLE,
        BODY
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotated priority encoder: first set request strictly after the pointer, wrapping.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx,
    output logic            any
);

    // One extra bit so ptr + offset (at most 2N-1) never overflows before the wrap.
    logic [IdxW:0] cand;

    // Walk candidates ptr+1 .. ptr+N and keep the first requester.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 1; i <= int'(N); i++) begin
            cand = {1'b0, ptr} + (IdxW + 1)'(i);
            if (cand >= (IdxW + 1)'(N)) begin
                cand = cand - (IdxW + 1)'(N);
            end
            if (!any && req[cand[IdxW-1:0]]) begin
                any = 1'b1;
                idx = cand[IdxW-1:0];
            end
        end
        for (int j = 0; j < int'(N); j++) begin
            gnt[j] = any && (idx == IdxW'(j));
        end
    end

endmodule

// File: rtl/rs232_tx_arb.sv
// Round-robin packet arbiter feeding one registered byte stream to the RS-232 sender.
module rs232_tx_arb
    import rs232_pkg::*;
#(
    parameter int unsigned NUM_CHAN = 4,
    parameter int unsigned HEADER   = 1,
    parameter int unsigned MAX_LEN  = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [8*NUM_CHAN-1:0] in_data,
    input  logic [NUM_CHAN-1:0]   in_valid,
    input  logic [NUM_CHAN-1:0]   in_last,
    output logic [NUM_CHAN-1:0]   in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_CHAN-1:0]   grant,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned IdxW    = $clog2(NUM_CHAN);
    localparam int unsigned ChanW   = $clog2(MAX_CHAN);
    localparam logic [15:0] LastCnt = 16'(MAX_LEN - 1);

    arb_state_e          state_q, state_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     gidx_q, gidx_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [NUM_CHAN-1:0] grant_q, grant_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          data_q;
    logic                valid_q;

    logic                load;
    logic [7:0]          load_data;
    logic                free;
    logic [7:0]          sel_data;
    logic                sel_valid;
    logic                sel_last;
    logic [NUM_CHAN-1:0] pick_gnt;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_any;

    rr_pick #(
        .N    (NUM_CHAN),
        .IdxW (IdxW)
    ) u_pick (
        .req (in_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign free      = !valid_q || out_ready;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign grant     = grant_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == BODY);
    // Only the owner sees ready, and only when the output stage can take a byte.
    assign in_ready  = (state_q == BODY && free) ? grant_q : '0;

    // Mux the owning channel's byte, valid and last using the one-hot grant.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < int'(NUM_CHAN); i++) begin
            if (grant_q[i]) begin
                sel_data  = in_data[8*i +: 8];
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
            end
        end
    end

    // Packet FSM: arbitrate in IDLE, stream the owner's bytes in BODY.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        overrun_d = 1'b0;
        load      = 1'b0;
        load_data = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_any && free) begin
                    state_d = BODY;
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    if (HEADER != 0) begin
                        load      = 1'b1;
                        load_data = RS232_HDR_BASE
                                  | {{(8 - ChanW){1'b0}}, ChanW'(pick_idx)};
                    end
                end
            end
            BODY: begin
                if (sel_valid && free) begin
                    load      = 1'b1;
                    load_data = sel_data;
                    cnt_d     = cnt_q + 16'd1;
                    if (sel_last || cnt_q == LastCnt) begin
                        state_d   = IDLE;
                        grant_d   = '0;
                        ptr_d     = gidx_q;
                        overrun_d = !sel_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and output register; reset clears everything immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= IdxW'(NUM_CHAN - 1);
            gidx_q    <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            overrun_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            overrun_q <= overrun_d;
            if (load) begin
                data_q  <= load_data;
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs232_tx_arb.sv
// Scoreboard bench: u0 default, u1 MAX_LEN=3, u2 HEADER=0.
module tb_rs232_tx_arb;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic        clock;
    logic        reset;
    logic [31:0] in_data   [3];
    logic [3:0]  in_valid  [3];
    logic [3:0]  in_last   [3];
    logic [3:0]  in_ready  [3];
    logic [7:0]  out_data  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [3:0]  grant     [3];
    logic        busy      [3];
    logic        overrun   [3];

    beat_t       chq   [12][$];
    logic [7:0]  exp_q [3][$];
    bit          acc   [12];
    int          ovr_cnt [3];
    int          out_cnt [3];
    int          n_checks;
    int          n_fail;

    rs232_tx_arb #(.NUM_CHAN(4), .HEADER(1), .MAX_LEN(256)) u0 (
        .clock(clock), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_last(in_last[0]), .in_ready(in_ready[0]), .out_data(out_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .grant(grant[0]),
        .busy(busy[0]), .overrun(overrun[0])
    );

    rs232_tx_arb #(.NUM_CHAN(4), .HEADER(1), .MAX_LEN(3)) u1 (
        .clock(clock), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_last(in_last[1]), .in_ready(in_ready[1]), .out_data(out_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .grant(grant[1]),
        .busy(busy[1]), .overrun(overrun[1])
    );

    rs232_tx_arb #(.NUM_CHAN(4), .HEADER(0), .MAX_LEN(256)) u2 (
        .clock(clock), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_last(in_last[2]), .in_ready(in_ready[2]), .out_data(out_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .grant(grant[2]),
        .busy(busy[2]), .overrun(overrun[2])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic push_beat(input int k, input int c, input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        chq[k*4+c].push_back(b);
    endtask

    task automatic push_exp(input int k, input logic [7:0] d);
        exp_q[k].push_back(d);
    endtask

    task automatic wait_drain(input int k);
        int n;
        n = 0;
        while (exp_q[k].size() != 0 && n < 200) begin
            @(negedge clock);
            #3;
            n++;
        end
        check($sformatf("drain%0d", k), exp_q[k].size(), 0);
    endtask

    // Producers present queue heads at negedge; monitor samples just before the posedge.
    initial begin
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = '0;
            in_last[k]  = '0;
            in_data[k]  = '0;
        end
        forever begin
            @(negedge clock);
            for (int i = 0; i < 12; i++) begin
                if (acc[i] && chq[i].size() != 0) begin
                    void'(chq[i].pop_front());
                end
            end
            for (int k = 0; k < 3; k++) begin
                for (int c = 0; c < 4; c++) begin
                    if (chq[k*4+c].size() != 0) begin
                        in_valid[k][c]       = 1'b1;
                        in_last[k][c]        = chq[k*4+c][0].last;
                        in_data[k][8*c +: 8] = chq[k*4+c][0].data;
                    end else begin
                        in_valid[k][c]       = 1'b0;
                        in_last[k][c]        = 1'b0;
                        in_data[k][8*c +: 8] = 8'h00;
                    end
                end
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                for (int c = 0; c < 4; c++) begin
                    acc[k*4+c] = in_valid[k][c] && in_ready[k][c];
                end
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                if (overrun[k]) ovr_cnt[k]++;
                if (out_valid[k] && out_ready[k]) begin
                    out_cnt[k]++;
                    check($sformatf("out_avail%0d", k), 32'(exp_q[k].size() > 0), 1);
                    if (exp_q[k].size() > 0) begin
                        check($sformatf("out_byte%0d", k), out_data[k], exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;

        // Reset values
        @(negedge clock);
        #3;
        check("rst_out_valid", out_valid[0], 0);
        check("rst_out_data", out_data[0], 0);
        check("rst_grant", grant[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_overrun", overrun[0], 0);
        check("rst_in_ready", in_ready[0], 0);
        @(negedge clock);
        reset = 1'b0;
        #3;

        // Contention: pointer starts at 3, so ch0, then ch3, then ch0 again
        push_beat(0, 0, 8'h41, 1'b1);
        push_beat(0, 0, 8'h43, 1'b1);
        push_beat(0, 3, 8'h42, 1'b1);
        push_exp(0, 8'hA0); push_exp(0, 8'h41);
        push_exp(0, 8'hA3); push_exp(0, 8'h42);
        push_exp(0, 8'hA0); push_exp(0, 8'h43);
        wait_drain(0);

        // Single packet on ch2
        push_beat(0, 2, 8'h11, 1'b0);
        push_beat(0, 2, 8'h22, 1'b1);
        push_exp(0, 8'hA2); push_exp(0, 8'h11); push_exp(0, 8'h22);
        n = 0;
        while (grant[0] == 4'b0000 && n < 50) begin
            @(negedge clock);
            #3;
            n++;
        end
        check("single_grant", grant[0], 4'b0100);
        check("single_busy", busy[0], 1);
        wait_drain(0);
        @(negedge clock);
        #3;
        check("idle_grant", grant[0], 0);
        check("idle_busy", busy[0], 0);

        // Backpressure on ch1 mid-packet
        for (int i = 0; i < 6; i++) push_beat(0, 1, 8'h70 + 8'(i), i == 5);
        push_exp(0, 8'hA1);
        for (int i = 0; i < 6; i++) push_exp(0, 8'h70 + 8'(i));
        n = 0;
        while (exp_q[0].size() > 4 && n < 50) begin
            @(negedge clock);
            #3;
            n++;
        end
        check("bp_reached", 32'(n < 50), 1);
        @(negedge clock);
        out_ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            check("bp_valid", out_valid[0], 1);
            check("bp_hold", out_data[0], (exp_q[0].size() > 0) ? exp_q[0][0] : 8'hxx);
            check("bp_in_ready", in_ready[0][1], 0);
            @(negedge clock);
        end
        out_ready[0] = 1'b1;
        wait_drain(0);

        // Reset in BODY with a byte held on the output
        for (int i = 0; i < 4; i++) push_beat(0, 1, 8'h90 + 8'(i), i == 3);
        push_exp(0, 8'hA1);
        for (int i = 0; i < 4; i++) push_exp(0, 8'h90 + 8'(i));
        n = 0;
        while (exp_q[0].size() > 3 && n < 50) begin
            @(negedge clock);
            #3;
            n++;
        end
        @(negedge clock);
        out_ready[0] = 1'b0;
        @(negedge clock);
        #3;
        check("prerst_valid", out_valid[0], 1);
        check("prerst_busy", busy[0], 1);
        reset = 1'b1;
        #1;
        check("midrst_valid", out_valid[0], 0);
        check("midrst_data", out_data[0], 0);
        check("midrst_grant", grant[0], 0);
        check("midrst_busy", busy[0], 0);
        check("midrst_in_ready", in_ready[0], 0);
        for (int c = 0; c < 12; c++) chq[c].delete();
        for (int k = 0; k < 3; k++) exp_q[k].delete();
        @(negedge clock);
        reset = 1'b0;
        out_ready[0] = 1'b1;
        #3;
        push_beat(0, 3, 8'hB3, 1'b1);
        push_beat(0, 0, 8'hB0, 1'b1);
        push_exp(0, 8'hA0); push_exp(0, 8'hB0);
        push_exp(0, 8'hA3); push_exp(0, 8'hB3);
        wait_drain(0);

        // MAX_LEN=3 forced release on u1, last never asserted
        for (int i = 0; i < 5; i++) push_beat(1, 1, 8'h30 + 8'(i), 1'b0);
        push_exp(1, 8'hA1); push_exp(1, 8'h30); push_exp(1, 8'h31); push_exp(1, 8'h32);
        push_exp(1, 8'hA1); push_exp(1, 8'h33); push_exp(1, 8'h34);
        wait_drain(1);
        check("ovr_pulses", ovr_cnt[1], 1);
        check("ovr_grant_held", grant[1], 4'b0010);

        // HEADER=0 on u2: ch0 wins first, no header bytes
        push_beat(2, 0, 8'h50, 1'b0);
        push_beat(2, 0, 8'h51, 1'b1);
        push_beat(2, 2, 8'h60, 1'b0);
        push_beat(2, 2, 8'h61, 1'b0);
        push_beat(2, 2, 8'h62, 1'b1);
        push_exp(2, 8'h50); push_exp(2, 8'h51);
        push_exp(2, 8'h60); push_exp(2, 8'h61); push_exp(2, 8'h62);
        wait_drain(2);
        repeat (3) @(negedge clock);
        #3;
        check("nohdr_count", out_cnt[2], 5);
        check("no_ovr0", ovr_cnt[0], 0);
        check("no_ovr2", ovr_cnt[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
